fifo_reader: RTL and testbench

//  Read-side engine for the BRAM-backed fifo: issues pops (re), absorbs the 1-cycle

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_reader_skid.sv | 72 +++++++
 rtl/fifo_reader.sv | 81 ++++++++
 tb/tb_fifo_reader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and occupancy encoding for the fifo read-side engine.
package fifo_pkg;

  localparam int FIFO_BRAM_RD_LAT  = 1;
  localparam int FIFO_RD_BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry output buffer: entry 0 is always the head, entry 1 only holds a word in OCC_TWO.
module fifo_reader_skid
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  flush,
  output occ_e                  occ,
  output logic [DATA_WIDTH-1:0] head
);

  occ_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
  logic [DATA_WIDTH-1:0] ent1_q, ent1_d;

  always_comb begin
    state_d = state_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      unique case (state_q)
        OCC_EMPTY: begin
          if (push) begin
            ent0_d  = push_data;
            state_d = OCC_ONE;
          end
        end
        OCC_ONE: begin
          // A simultaneous pop and push replaces the head in place.
          if (push && pop) begin
            ent0_d = push_data;
          end else if (push) begin
            ent1_d  = push_data;
            state_d = OCC_TWO;
          end else if (pop) begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (pop) begin
            ent0_d  = ent1_q;
            state_d = OCC_ONE;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OCC_EMPTY;
      ent0_q  <= '0;
      ent1_q  <= '0;
    end else begin
      state_q <= state_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
    end
  end

  assign occ  = state_q;
  assign head = ent0_q;

endmodule

// File: rtl/fifo_reader.sv
// Read-side engine: issues fifo pops, absorbs the BRAM read latency, drives a valid/ready stream.
// Optional frame marking on out_last is enabled by defining FIFO_READER_LAST_EN.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int PKT_LEN    = 64
) (
  input  logic                  r_clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_q,
  output logic                  fifo_re,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  occ_e       occ;
  logic       pop;
  logic       capture;
  logic       pend_q, pend_d;
  logic [2:0] level;
  logic [2:0] limit;

  assign out_valid = (occ != OCC_EMPTY);
  assign pop       = out_valid & out_ready;
  assign capture   = pend_q & ~flush;

  // Words buffered plus the one in flight must stay within the buffer after this cycle's pop.
  always_comb begin
    level   = {1'b0, occ} + {2'b00, pend_q};
    limit   = 3'(FIFO_RD_BUF_DEPTH) + {2'b00, pop};
    fifo_re = rst_n & ~fifo_empty & ~flush & (level < limit);
    pend_d  = fifo_re;
  end

  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) pend_q <= 1'b0;
    else        pend_q <= pend_d;
  end

  fifo_reader_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (r_clk),
    .rst_n    (rst_n),
    .push     (capture),
    .push_data(fifo_q),
    .pop      (pop),
    .flush    (flush),
    .occ      (occ),
    .head     (out_data)
  );

`ifdef FIFO_READER_LAST_EN
  localparam int CNT_W = $clog2(PKT_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PKT_LEN - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (flush)    cnt_d = '0;
    else if (pop) cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign out_last = out_valid & (cnt_q == LAST_IDX);
`else
  // Always low for any legal PKT_LEN (>= 1).
  assign out_last = out_valid & (PKT_LEN < 1);
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: queue-based fifo source, word scoreboard with arrival stamps.
module tb_fifo_reader;
  localparam int DW = 16;
  localparam int PL = 4;

  typedef struct {
    logic [DW-1:0] d;
    int            stamp;
  } ent_t;

  logic          r_clk      = 1'b0;
  logic          rst_n      = 1'b0;
  logic          fifo_empty = 1'b0;
  logic [DW-1:0] fifo_q     = '0;
  logic          flush      = 1'b0;
  logic          out_ready  = 1'b0;
  logic          fifo_re;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;

  always #5 r_clk = ~r_clk;

  fifo_reader #(
    .DATA_WIDTH(DW),
    .PKT_LEN   (PL)
  ) dut (
    .r_clk     (r_clk),
    .rst_n     (rst_n),
    .fifo_empty(fifo_empty),
    .fifo_q    (fifo_q),
    .fifo_re   (fifo_re),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0] src[$];
  ent_t          sb[$];
  logic [DW-1:0] got[$];
  bit            got_last[$];
  int edge_cnt = 0, cyc = 0, frame = 0;
  int re_cnt = 0, re_first = -1, vld_first = -1, beat_first = -1, beat_last = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic reset_vars();
    got.delete();
    got_last.delete();
    re_cnt = 0; re_first = -1; vld_first = -1; beat_first = -1; beat_last = -1; cyc = 0;
  endtask

  task automatic load(input logic [DW-1:0] first, input int n);
    for (int i = 0; i < n; i++) src.push_back(first + DW'(i));
  endtask

  // One clock: drive inputs, compare outputs against the scoreboard, then advance the model.
  task automatic cycle(input bit rdy, input bit fl, input bit hold);
    bit            exp_valid, exp_last, exp_re, pop_m, re_s, vld_s, lst_s;
    logic [DW-1:0] dat_s, w;
    @(negedge r_clk);
    out_ready  = rdy;
    flush      = fl;
    fifo_empty = (src.size() == 0) || hold;
    #1;
    re_s  = fifo_re;
    vld_s = out_valid;
    dat_s = out_data;
    lst_s = out_last;
    exp_valid = (sb.size() > 0) && (sb[0].stamp <= edge_cnt - 1);
    pop_m     = exp_valid && rdy;
`ifdef FIFO_READER_LAST_EN
    exp_last = exp_valid && (frame == PL - 1);
`else
    exp_last = 1'b0;
`endif
    exp_re = !fifo_empty && !fl && ((sb.size() - (pop_m ? 1 : 0)) < 2);
    chk("out_valid", 32'(vld_s), 32'(exp_valid));
    if (exp_valid) chk("out_data", 32'(dat_s), 32'(sb[0].d));
    chk("out_last", 32'(lst_s), 32'(exp_last));
    chk("fifo_re", 32'(re_s), 32'(exp_re));
    if (re_s) begin
      re_cnt++;
      if (re_first < 0) re_first = cyc;
    end
    if (vld_s && vld_first < 0) vld_first = cyc;
    if (vld_s && rdy) begin
      got.push_back(dat_s);
      got_last.push_back(lst_s);
      if (beat_first < 0) beat_first = cyc;
      beat_last = cyc;
    end
    @(posedge r_clk);
    edge_cnt++;
    cyc++;
    if (fl) begin
      sb.delete();
      frame = 0;
    end else if (pop_m) begin
      void'(sb.pop_front());
      frame = (frame == PL - 1) ? 0 : frame + 1;
    end
    w = 16'hDEAD;
    if (re_s) begin
      if (src.size() > 0) w = src.pop_front();
      sb.push_back('{d: w, stamp: edge_cnt});
    end
    #1;
    if (re_s) fifo_q = w;
  endtask

  task automatic drain();
    bit done;
    for (int i = 0; i < 100 && !(src.size() == 0 && sb.size() == 0); i++) cycle(1'b1, 1'b0, 1'b0);
    done = (src.size() == 0) && (sb.size() == 0);
    chk("drain_done", 32'(done), 32'd1);
  endtask

  task automatic check_seq(input logic [DW-1:0] first, input int n);
    chk("got_len", 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++) chk("got_word", 32'(got[i]), 32'(first + DW'(i)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, with fifo non-empty so reset gating of fifo_re is visible.
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_fifo_re", 32'(fifo_re), 32'd0);
    fifo_empty = 1'b1;
    repeat (2) @(negedge r_clk);
    rst_n = 1'b1;

    // Streaming: 8 words, ready held high.
    reset_vars();
    load(16'h0001, 8);
    repeat (12) cycle(1'b1, 1'b0, 1'b0);
    drain();
    chk("stream_latency", 32'(vld_first - re_first), 32'd2);
    chk("stream_beats", 32'(beat_last - beat_first), 32'd7);
    check_seq(16'h0001, 8);

    // Backpressure: ready low for 10 cycles with 5 words queued.
    reset_vars();
    load(16'h0001, 5);
    repeat (10) cycle(1'b0, 1'b0, 1'b0);
    chk("bp_pops", 32'(re_cnt), 32'd2);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_head", 32'(out_data), 32'h0001);
    drain();
    check_seq(16'h0001, 5);

    // Boundary: empty toggling every cycle, random ready.
    reset_vars();
    load(16'h0101, 20);
    for (int i = 0; i < 120; i++) cycle(1'($urandom_range(0, 1)), 1'b0, 1'(i % 2));
    drain();
    check_seq(16'h0101, 20);

    // Flush with one word buffered and one in flight.
    reset_vars();
    load(16'h0041, 4);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    drain();
    check_seq(16'h0043, 2);

    // Asynchronous reset mid-stream with two words buffered.
    reset_vars();
    load(16'h0021, 5);
    repeat (4) cycle(1'b0, 1'b0, 1'b0);
    chk("pre_rst_head", 32'(out_data), 32'h0021);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_out_last", 32'(out_last), 32'd0);
    chk("arst_fifo_re", 32'(fifo_re), 32'd0);
    sb.delete();
    frame = 0;
    repeat (2) begin
      @(negedge r_clk);
      fifo_empty = 1'b0;
      #1 chk("rst_hold_fifo_re", 32'(fifo_re), 32'd0);
    end
    @(negedge r_clk);
    fifo_empty = 1'b1;
    rst_n = 1'b1;
    drain();
    check_seq(16'h0023, 3);

`ifdef FIFO_READER_LAST_EN
    // Frame marking: start from a cleared counter.
    cycle(1'b0, 1'b1, 1'b1);
    reset_vars();
    load(16'h0051, 10);
    drain();
    chk("last_len", 32'(got_last.size()), 32'd10);
    for (int i = 0; i < got_last.size(); i++)
      chk("last_flag", 32'(got_last[i]), 32'((i == 3) || (i == 7)));

    // Flush after word 6 restarts the frame.
    reset_vars();
    load(16'h0061, 14);
    for (int i = 0; i < 50 && got.size() < 6; i++) cycle(1'b1, 1'b0, 1'b0);
    chk("pre_flush_words", 32'(got.size()), 32'd6);
    cycle(1'b0, 1'b1, 1'b0);
    drain();
    chk("post_flush_enough", 32'(got.size() >= 10), 32'd1);
    for (int j = 6; j < got_last.size(); j++)
      chk("post_flush_last", 32'(got_last[j]), 32'((j - 6) == 3));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
